// File: rtl/fp_add_sub_unit.sv
// -----------------------------------------------------------------------------
// fp_add_sub_unit
//   Multi-cycle IEEE-754 add/subtract for the FP execute stage. Operands come
//   straight from the FP register file; the result, destination register and
//   write enable go to FP write-back. Rounding is toward zero (truncation),
//   denormal inputs and results are flushed to zero. Latency is fixed at four
//   cycles from acceptance to done.
//
//   Single and double share one datapath: single operands are unpacked into
//   the double-width mantissa (left-justified) with their own exponent limits,
//   so the extra low mantissa bits simply act as additional guard precision.
//
// Ports
//   clk             in   1   clock, all state updates on posedge
//   reset           in   1   asynchronous active-high reset
//   start           in   1   operation request, sampled only in IDLE
//   fmt             in   5   5'h10 single, 5'h11 double, others unsupported
//   op_sub          in   1   0 = A+B, 1 = A-B
//   FPReadData1     in   64  operand A
//   FPReadData2     in   64  operand B
//   dest_reg        in   5   destination FP register
//   busy            out  1   high from acceptance until return to IDLE
//   done            out  1   one-cycle pulse, result fields valid while high
//   FPResult        out  64  result (single zero-fills [63:32])
//   FPWriteRegister out  5   registered destination register
//   FPRegWrite      out  1   done, masked for unsupported fmt or dest_reg==0
//   flag_invalid    out  1   NaN input, Inf-Inf, or unsupported fmt
//   flag_overflow   out  1   result exponent overflowed
// -----------------------------------------------------------------------------
module fp_add_sub_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  fmt,
   input  logic        op_sub,
   input  logic [63:0] FPReadData1,
   input  logic [63:0] FPReadData2,
   input  logic [4:0]  dest_reg,
   output logic        busy,
   output logic        done,
   output logic [63:0] FPResult,
   output logic [4:0]  FPWriteRegister,
   output logic        FPRegWrite,
   output logic        flag_invalid,
   output logic        flag_overflow
);

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

   state_t             r_state;
   // operand capture (held for the whole operation)
   logic [63:0]        r_a, r_b;
   logic [4:0]         r_fmt;
   logic               r_sub;
   logic [4:0]         r_dest;
   // ALIGN results
   logic [55:0]        r_big, r_small;
   logic [10:0]        r_exp;
   logic               r_sign, r_eff_sub;
   logic               r_nan, r_inf, r_inf_sign, r_zero_sign;
   // ADD result
   logic [56:0]        r_sum;
   // NORM results
   logic [55:0]        r_mant;
   logic signed [12:0] r_nexp;
   logic               r_res_zero;
   // registered outputs
   logic               r_busy, r_done, r_reg_write, r_invalid, r_overflow;
   logic [63:0]        r_result;
   logic [4:0]         r_wreg;

   // ---------------------------------------------------------------- unpack
   logic        w_single, w_fmt_ok;
   logic [10:0] w_exp_max;
   logic        w_a_sign, w_b_sign, w_b_esign;
   logic [10:0] w_a_exp, w_b_exp;
   logic [51:0] w_a_frac, w_b_frac;

   always_comb begin
      w_single  = (r_fmt == 5'h10);
      w_fmt_ok  = w_single || (r_fmt == 5'h11);
      w_exp_max = w_single ? 11'h0FF : 11'h7FF;
      if (w_single) begin
         w_a_sign = r_a[31];
         w_a_exp  = {3'b000, r_a[30:23]};
         w_a_frac = {r_a[22:0], 29'd0};
         w_b_sign = r_b[31];
         w_b_exp  = {3'b000, r_b[30:23]};
         w_b_frac = {r_b[22:0], 29'd0};
      end else begin
         w_a_sign = r_a[63];
         w_a_exp  = r_a[62:52];
         w_a_frac = r_a[51:0];
         w_b_sign = r_b[63];
         w_b_exp  = r_b[62:52];
         w_b_frac = r_b[51:0];
      end
      w_b_esign = w_b_sign ^ r_sub;
   end

   logic        w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
   logic [52:0] w_a_mant, w_b_mant;

   assign w_a_zero = (w_a_exp == 11'd0);
   assign w_b_zero = (w_b_exp == 11'd0);
   assign w_a_nan  = (w_a_exp == w_exp_max) && (w_a_frac != 52'd0);
   assign w_b_nan  = (w_b_exp == w_exp_max) && (w_b_frac != 52'd0);
   assign w_a_inf  = (w_a_exp == w_exp_max) && (w_a_frac == 52'd0);
   assign w_b_inf  = (w_b_exp == w_exp_max) && (w_b_frac == 52'd0);
   // denormals have exponent 0 and are treated as zero
   assign w_a_mant = w_a_zero ? 53'd0 : {1'b1, w_a_frac};
   assign w_b_mant = w_b_zero ? 53'd0 : {1'b1, w_b_frac};

   // ----------------------------------------------------------------- align
   logic        w_swap;
   logic [10:0] w_big_exp, w_small_exp, w_diff;
   logic [52:0] w_big_mant, w_small_mant;
   logic        w_big_sign, w_small_sign;
   logic [55:0] w_small_ext, w_shift_mask, w_small_aligned;

   always_comb begin
      w_swap       = {w_b_exp, w_b_mant} > {w_a_exp, w_a_mant};
      w_big_exp    = w_swap ? w_b_exp   : w_a_exp;
      w_big_mant   = w_swap ? w_b_mant  : w_a_mant;
      w_big_sign   = w_swap ? w_b_esign : w_a_sign;
      w_small_exp  = w_swap ? w_a_exp   : w_b_exp;
      w_small_mant = w_swap ? w_a_mant  : w_b_mant;
      w_small_sign = w_swap ? w_a_sign  : w_b_esign;
      w_diff       = w_big_exp - w_small_exp;
      w_small_ext  = {w_small_mant, 3'b000};
      w_shift_mask = 56'd0;
      if (w_diff >= 11'd56) begin
         // everything shifts past the guard bits: only stickiness survives
         w_small_aligned = {55'd0, |w_small_ext};
      end else begin
         w_shift_mask    = ~({56{1'b1}} << w_diff[5:0]);
         w_small_aligned = (w_small_ext >> w_diff[5:0])
                         | {55'd0, |(w_small_ext & w_shift_mask)};
      end
   end

   // ------------------------------------------------------------------- add
   logic [56:0] w_sum;
   assign w_sum = r_eff_sub ? ({1'b0, r_big} - {1'b0, r_small})
                            : ({1'b0, r_big} + {1'b0, r_small});

   // ------------------------------------------------------------- normalise
   logic [5:0]         w_lzc;
   logic [55:0]        w_norm_mant;
   logic signed [12:0] w_norm_exp;

   always_comb begin
      // last hit wins, so this reports the highest set bit
      w_lzc = 6'd0;
      for (int i = 0; i < 56; i++) begin
         if (r_sum[i]) w_lzc = 6'(55 - i);
      end
      if (r_sum[56]) begin
         w_norm_mant = r_sum[56:1];
         w_norm_exp  = $signed({2'b00, r_exp}) + 13'sd1;
      end else begin
         w_norm_mant = r_sum[55:0] << w_lzc;
         w_norm_exp  = $signed({2'b00, r_exp}) - $signed({7'd0, w_lzc});
      end
   end

   // ------------------------------------------------------------------ pack
   logic signed [12:0] w_exp_lim;
   logic               w_pk_sign, w_inv, w_ovf;
   logic [10:0]        w_pk_exp;
   logic [51:0]        w_pk_frac;
   logic [63:0]        w_result;

   always_comb begin
      w_exp_lim = w_single ? 13'sd255 : 13'sd2047;
      w_inv     = 1'b0;
      w_ovf     = 1'b0;
      w_pk_sign = r_sign;
      w_pk_exp  = r_nexp[10:0];
      w_pk_frac = r_mant[54:3];
      if (r_inf) begin
         w_pk_sign = r_inf_sign;
         w_pk_exp  = w_exp_max;
         w_pk_frac = 52'd0;
      end else if (r_res_zero) begin
         w_pk_sign = r_zero_sign;
         w_pk_exp  = 11'd0;
         w_pk_frac = 52'd0;
      end else if (r_nexp >= w_exp_lim) begin
         // truncation saturates at the largest finite magnitude
         w_ovf     = 1'b1;
         w_pk_exp  = w_exp_max - 11'd1;
         w_pk_frac = {52{1'b1}};
      end else if (r_nexp <= 13'sd0) begin
         w_pk_exp  = 11'd0;
         w_pk_frac = 52'd0;
      end
      w_result = w_single ? {32'd0, w_pk_sign, w_pk_exp[7:0], w_pk_frac[51:29]}
                          : {w_pk_sign, w_pk_exp, w_pk_frac};
      if (!w_fmt_ok) begin
         w_result = 64'd0;
         w_inv    = 1'b1;
         w_ovf    = 1'b0;
      end else if (r_nan) begin
         w_result = w_single ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;
         w_inv    = 1'b1;
         w_ovf    = 1'b0;
      end
   end

   // hidden bit and guard bits are dropped by truncation
   logic w_unused;
   assign w_unused = ^{r_mant[55], r_mant[2:0]};

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_a         <= 64'd0;
         r_b         <= 64'd0;
         r_fmt       <= 5'd0;
         r_sub       <= 1'b0;
         r_dest      <= 5'd0;
         r_big       <= 56'd0;
         r_small     <= 56'd0;
         r_exp       <= 11'd0;
         r_sign      <= 1'b0;
         r_eff_sub   <= 1'b0;
         r_nan       <= 1'b0;
         r_inf       <= 1'b0;
         r_inf_sign  <= 1'b0;
         r_zero_sign <= 1'b0;
         r_sum       <= 57'd0;
         r_mant      <= 56'd0;
         r_nexp      <= 13'sd0;
         r_res_zero  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_reg_write <= 1'b0;
         r_invalid   <= 1'b0;
         r_overflow  <= 1'b0;
         r_result    <= 64'd0;
         r_wreg      <= 5'd0;
      end else begin
         r_done      <= 1'b0;
         r_reg_write <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= FPReadData1;
                  r_b     <= FPReadData2;
                  r_fmt   <= fmt;
                  r_sub   <= op_sub;
                  r_dest  <= dest_reg;
                  r_busy  <= 1'b1;
                  r_state <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               r_big       <= {w_big_mant, 3'b000};
               r_small     <= w_small_aligned;
               r_exp       <= w_big_exp;
               r_sign      <= w_big_sign;
               r_eff_sub   <= w_big_sign ^ w_small_sign;
               r_nan       <= w_a_nan || w_b_nan ||
                              (w_a_inf && w_b_inf && (w_a_sign != w_b_esign));
               r_inf       <= w_a_inf || w_b_inf;
               r_inf_sign  <= w_a_inf ? w_a_sign : w_b_esign;
               // an exact zero is negative only when both addends are negative
               r_zero_sign <= w_a_sign & w_b_esign;
               r_state     <= S_ADD;
            end
            S_ADD: begin
               r_sum   <= w_sum;
               r_state <= S_NORM;
            end
            S_NORM: begin
               r_mant     <= w_norm_mant;
               r_nexp     <= w_norm_exp;
               r_res_zero <= (r_sum == 57'd0);
               r_state    <= S_DONE;
            end
            S_DONE: begin
               r_result    <= w_result;
               r_invalid   <= w_inv;
               r_overflow  <= w_ovf;
               r_wreg      <= r_dest;
               r_done      <= 1'b1;
               r_reg_write <= w_fmt_ok && (r_dest != 5'd0);
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy            = r_busy;
   assign done            = r_done;
   assign FPResult        = r_result;
   assign FPWriteRegister = r_wreg;
   assign FPRegWrite      = r_reg_write;
   assign flag_invalid    = r_invalid;
   assign flag_overflow   = r_overflow;

endmodule

// File: tb/tb_fp_add_sub_unit.sv
// -----------------------------------------------------------------------------
// tb_fp_add_sub_unit
//   Self-checking bench for fp_add_sub_unit. Each issued operation pushes its
//   expected write-back onto a scoreboard queue; the entry is popped and
//   compared when the done pulse arrives.
// -----------------------------------------------------------------------------
module tb_fp_add_sub_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  fmt;
   logic        op_sub;
   logic [63:0] FPReadData1, FPReadData2;
   logic [4:0]  dest_reg;
   logic        busy, done, FPRegWrite, flag_invalid, flag_overflow;
   logic [63:0] FPResult;
   logic [4:0]  FPWriteRegister;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [4:0]  fmt;
      logic        sub;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  dest;
      logic [63:0] res;
      logic        inv;
      logic        ovf;
      logic        we;
   } vec_t;

   typedef struct packed {
      logic [63:0] res;
      logic        inv;
      logic        ovf;
      logic        we;
      logic [4:0]  dest;
   } exp_t;

   exp_t sb_q[$];

   fp_add_sub_unit dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .fmt             (fmt),
      .op_sub          (op_sub),
      .FPReadData1     (FPReadData1),
      .FPReadData2     (FPReadData2),
      .dest_reg        (dest_reg),
      .busy            (busy),
      .done            (done),
      .FPResult        (FPResult),
      .FPWriteRegister (FPWriteRegister),
      .FPRegWrite      (FPRegWrite),
      .flag_invalid    (flag_invalid),
      .flag_overflow   (flag_overflow)
   );

   always #5 clk = ~clk;

   // Drive one request for a single cycle; optionally record its expectation.
   task automatic issue(input vec_t v, input bit push);
      @(negedge clk);
      fmt         = v.fmt;
      op_sub      = v.sub;
      FPReadData1 = v.a;
      FPReadData2 = v.b;
      dest_reg    = v.dest;
      start       = 1'b1;
      if (push) sb_q.push_back('{v.res, v.inv, v.ovf, v.we, v.dest});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done; lat counts edges after the accepting edge.
   task automatic collect(output int lat, output bit got);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         if (done === 1'b1) got = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if ({busy, done, FPResult, FPWriteRegister, FPRegWrite, flag_invalid, flag_overflow} !== 74'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b res=%h wreg=%0d we=%b inv=%b ovf=%b, required all zero",
                  busy, done, FPResult, FPWriteRegister, FPRegWrite, flag_invalid, flag_overflow);
      end
      $display("reset: outputs busy=%b done=%b res=%h", busy, done, FPResult);
   endtask

   task automatic test_arith();
      vec_t vecs[$];
      exp_t e;
      int   lat;
      bit   got;
      vecs.push_back('{5'h10, 1'b0, 64'h3F800000, 64'h40000000, 5'd3, 64'h40400000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h3F800000, 64'h33800000, 5'd4, 64'h3F800000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b1, 64'h40400000, 64'h3F800000, 5'd5, 64'h40000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b1, 64'h3F800000, 64'h40400000, 5'd6, 64'hC0000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b1, 64'h3F800000, 64'h30800000, 5'd7, 64'h3F7FFFFF, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'hC0000000, 64'h3F800000, 5'd8, 64'hBF800000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h3FC00000, 64'h3FC00000, 5'd9, 64'h40400000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h11, 1'b1, 64'h3FF8000000000000, 64'h3FF8000000000000, 5'd10, 64'h0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h11, 1'b0, 64'h3FF0000000000000, 64'h4000000000000000, 5'd11, 64'h4008000000000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h11, 1'b0, 64'h3FF0000000000000, 64'h3CA0000000000000, 5'd12, 64'h3FF0000000000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h11, 1'b1, 64'h3FF0000000000000, 64'h3C30000000000000, 5'd13, 64'h3FEFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1});
      foreach (vecs[i]) begin
         issue(vecs[i], 1'b1);
         collect(lat, got);
         e = sb_q.pop_front();
         n_checks++;
         if (!got || lat != 4) begin
            n_fail++;
            $display("FAIL arith[%0d] latency: got %0d (done seen %0b), required 4", i, lat, got);
         end
         n_checks++;
         if (FPResult !== e.res) begin
            n_fail++;
            $display("FAIL arith[%0d] result: got %h, required %h", i, FPResult, e.res);
         end
         n_checks++;
         if ({flag_invalid, flag_overflow, FPRegWrite, FPWriteRegister} !== {e.inv, e.ovf, e.we, e.dest}) begin
            n_fail++;
            $display("FAIL arith[%0d] wb/flags: got inv=%b ovf=%b we=%b wreg=%0d, required inv=%b ovf=%b we=%b wreg=%0d",
                     i, flag_invalid, flag_overflow, FPRegWrite, FPWriteRegister, e.inv, e.ovf, e.we, e.dest);
         end
         $display("arith[%0d]: a=%h b=%h sub=%b -> %h lat=%0d", i, vecs[i].a, vecs[i].b, vecs[i].sub, FPResult, lat);
      end
   endtask

   task automatic test_specials();
      vec_t vecs[$];
      exp_t e;
      int   lat;
      bit   got;
      vecs.push_back('{5'h10, 1'b1, 64'h7F800000, 64'h7F800000, 5'd1, 64'h7FC00000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h7F7FFFFF, 64'h7F7FFFFF, 5'd2, 64'h7F7FFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'hFF7FFFFF, 64'hFF7FFFFF, 5'd3, 64'hFF7FFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h7F800000, 64'h3F800000, 5'd4, 64'h7F800000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b1, 64'h3F800000, 64'h7F800000, 5'd5, 64'hFF800000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h7F800001, 64'h3F800000, 5'd6, 64'h7FC00000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h3F800000, 64'hFFC00000, 5'd7, 64'h7FC00000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h80000000, 64'h80000000, 5'd8, 64'h80000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b1, 64'h80000000, 64'h00000000, 5'd9, 64'h80000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h00000000, 64'h80000000, 5'd10, 64'h00000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b0, 64'h00000001, 64'h3F800000, 5'd11, 64'h3F800000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b1, 64'h00800001, 64'h00800000, 5'd12, 64'h00000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h10, 1'b1, 64'h80800001, 64'h80800000, 5'd13, 64'h80000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h11, 1'b0, 64'h7FF0000000000000, 64'hFFF0000000000000, 5'd14, 64'h7FF8000000000000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{5'h11, 1'b1, 64'hFFF0000000000000, 64'h7FF0000000000000, 5'd15, 64'hFFF0000000000000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h11, 1'b0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 5'd16, 64'h7FEFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{5'h11, 1'b0, 64'h7FF0000000000001, 64'h3FF0000000000000, 5'd17, 64'h7FF8000000000000, 1'b1, 1'b0, 1'b1});
      foreach (vecs[i]) begin
         issue(vecs[i], 1'b1);
         collect(lat, got);
         e = sb_q.pop_front();
         n_checks++;
         if (!got || lat != 4) begin
            n_fail++;
            $display("FAIL special[%0d] latency: got %0d (done seen %0b), required 4", i, lat, got);
         end
         n_checks++;
         if (FPResult !== e.res) begin
            n_fail++;
            $display("FAIL special[%0d] result: got %h, required %h", i, FPResult, e.res);
         end
         n_checks++;
         if ({flag_invalid, flag_overflow, FPRegWrite, FPWriteRegister} !== {e.inv, e.ovf, e.we, e.dest}) begin
            n_fail++;
            $display("FAIL special[%0d] wb/flags: got inv=%b ovf=%b we=%b wreg=%0d, required inv=%b ovf=%b we=%b wreg=%0d",
                     i, flag_invalid, flag_overflow, FPRegWrite, FPWriteRegister, e.inv, e.ovf, e.we, e.dest);
         end
         $display("special[%0d]: a=%h b=%h sub=%b -> %h inv=%b ovf=%b", i, vecs[i].a, vecs[i].b, vecs[i].sub,
                  FPResult, flag_invalid, flag_overflow);
      end
   endtask

   task automatic test_formats();
      vec_t vecs[$];
      exp_t e;
      int   lat;
      bit   got;
      vecs.push_back('{5'h10, 1'b0, 64'hDEADBEEF3F800000, 64'h1234567840000000, 5'd9, 64'h0000000040400000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'h14, 1'b0, 64'h3F800000, 64'h40000000, 5'd7, 64'h0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{5'h11, 1'b0, 64'h3FF0000000000000, 64'h4000000000000000, 5'd0, 64'h4008000000000000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'h10, 1'b0, 64'h3F800000, 64'h40000000, 5'd31, 64'h40400000, 1'b0, 1'b0, 1'b1});
      foreach (vecs[i]) begin
         issue(vecs[i], 1'b1);
         collect(lat, got);
         e = sb_q.pop_front();
         n_checks++;
         if (!got || lat != 4) begin
            n_fail++;
            $display("FAIL format[%0d] latency: got %0d (done seen %0b), required 4", i, lat, got);
         end
         n_checks++;
         if (FPResult !== e.res) begin
            n_fail++;
            $display("FAIL format[%0d] result: got %h, required %h", i, FPResult, e.res);
         end
         n_checks++;
         if ({flag_invalid, flag_overflow, FPRegWrite, FPWriteRegister} !== {e.inv, e.ovf, e.we, e.dest}) begin
            n_fail++;
            $display("FAIL format[%0d] wb/flags: got inv=%b ovf=%b we=%b wreg=%0d, required inv=%b ovf=%b we=%b wreg=%0d",
                     i, flag_invalid, flag_overflow, FPRegWrite, FPWriteRegister, e.inv, e.ovf, e.we, e.dest);
         end
         $display("format[%0d]: fmt=%h dest=%0d -> %h we=%b inv=%b", i, vecs[i].fmt, vecs[i].dest,
                  FPResult, FPRegWrite, flag_invalid);
      end
   endtask

   // start held high through ALIGN and ADD with different operands must be ignored
   task automatic test_back_to_back();
      exp_t        e;
      int          ndone;
      logic [63:0] res_seen;
      @(negedge clk);
      fmt = 5'h10; op_sub = 1'b0; dest_reg = 5'd21; start = 1'b1;
      FPReadData1 = 64'h3F800000; FPReadData2 = 64'h40000000;
      sb_q.push_back('{64'h40400000, 1'b0, 1'b0, 1'b1, 5'd21});
      @(posedge clk);
      @(negedge clk);
      FPReadData1 = 64'h41200000; FPReadData2 = 64'h41200000; dest_reg = 5'd22;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      res_seen = 64'hX;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            res_seen = FPResult;
         end
      end
      e = sb_q.pop_front();
      n_checks++;
      if (ndone != 1) begin
         n_fail++;
         $display("FAIL ignore_start done_count: got %0d, required 1", ndone);
      end
      n_checks++;
      if (res_seen !== e.res) begin
         n_fail++;
         $display("FAIL ignore_start result: got %h, required %h", res_seen, e.res);
      end
      $display("back_to_back: dones=%0d result=%h", ndone, res_seen);
   endtask

   // reset in NORM aborts; no done afterwards, then the unit still works
   task automatic test_reset_abort();
      vec_t v;
      exp_t e;
      int   ndone, lat;
      bit   got;
      v = '{5'h10, 1'b0, 64'h40000000, 64'h40000000, 5'd5, 64'h40800000, 1'b0, 1'b0, 1'b1};
      issue(v, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, FPResult, FPWriteRegister, FPRegWrite, flag_invalid, flag_overflow} !== 74'd0) begin
         n_fail++;
         $display("FAIL abort_reset_outputs: busy=%b done=%b res=%h wreg=%0d we=%b inv=%b ovf=%b, required all zero",
                  busy, done, FPResult, FPWriteRegister, FPRegWrite, flag_invalid, flag_overflow);
      end
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      n_checks++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d done pulses, required 0", ndone);
      end
      $display("reset_abort: dones after abort=%0d", ndone);
      issue(v, 1'b1);
      collect(lat, got);
      e = sb_q.pop_front();
      n_checks++;
      if (!got || FPResult !== e.res) begin
         n_fail++;
         $display("FAIL abort_recover: got %h (done seen %0b), required %h", FPResult, got, e.res);
      end
      $display("reset_abort: recovery op -> %h lat=%0d", FPResult, lat);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; fmt = 5'h10; op_sub = 1'b0;
      FPReadData1 = 64'd0; FPReadData2 = 64'd0; dest_reg = 5'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_arith();
      test_specials();
      test_formats();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
